lattice_decoder: RTL and testbench

Receive-side counterpart of the 5-bit symbol encoder. It takes one received, quantized sample per dimension (dim0: 4-PAM, dim1: 4-PAM, dim2: 2-PAM) and slices each to the nearest constellation level. It demaps the Gray labels back to the 5-bit data word and flags low-confidence decisions. It sits after the channel/ADC model and feeds the data sink; a valid/ready stream with global stall runs on the 500 MHz symbol clock.

---
 rtl/lattice_pkg.sv | 34 +++
 rtl/pam_slicer.sv | 72 +++++++
 rtl/lattice_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_lattice_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lattice_pkg.sv
// Shared definitions for the 5-bit lattice symbol encoder/decoder pair.
package lattice_pkg;

    // Level index 0..3 maps to -3, -1, +1, +3 times the unit spacing.
    typedef logic [1:0] level_idx_t;

    // Two-bit Gray label carried by one 4-PAM dimension.
    typedef logic [1:0] gray_label_t;

    // Data word layout: {dim0 label, dim1 label, dim2 bit}.
    localparam int unsigned DIM0_BITS = 2;
    localparam int unsigned DIM1_BITS = 2;
    localparam int unsigned DIM2_BITS = 1;
    localparam int unsigned WORD_BITS = DIM0_BITS + DIM1_BITS + DIM2_BITS;

    // Decision threshold shared by 2-PAM and the centre of 4-PAM.
    localparam int PAM_CENTER_THR = 0;

    // Outer 4-PAM thresholds sit at +/- twice the unit spacing.
    function automatic int pam4_outer_thr(input int scale);
        return 2 * scale;
    endfunction

    // Index -> Gray label: 0->00, 1->01, 2->11, 3->10.
    function automatic gray_label_t gray_label(input level_idx_t idx);
        return {idx[1], idx[1] ^ idx[0]};
    endfunction

    // Gray label -> index, used by the encoder side.
    function automatic level_idx_t gray_index(input gray_label_t label);
        return {label[1], label[1] ^ label[0]};
    endfunction

endpackage

// File: rtl/pam_slicer.sv
// Combinational nearest-level slicer for one PAM dimension with a near-threshold flag.
module pam_slicer
    import lattice_pkg::*;
#(
    parameter int unsigned LEVELS       = 4,
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned SCALE        = 32,
    parameter int unsigned MARGIN       = 8
) (
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    output level_idx_t                     idx,
    output gray_label_t                    label,
    output logic                           near
);

    // Two guard bits keep |sample - threshold| free of overflow.
    localparam int unsigned CW = SAMPLE_WIDTH + 2;
    localparam bit IS_PAM4 = (LEVELS == 4);

    localparam logic signed [CW-1:0] THR_HI   = CW'(pam4_outer_thr(int'(SCALE)));
    localparam logic signed [CW-1:0] THR_LO   = -THR_HI;
    localparam logic signed [CW-1:0] THR_MID  = CW'(PAM_CENTER_THR);
    localparam logic signed [CW-1:0] MARGIN_S = CW'(MARGIN);

    function automatic logic signed [CW-1:0] abs_s(input logic signed [CW-1:0] v);
        return v[CW-1] ? -v : v;
    endfunction

    logic signed [CW-1:0] sx;
    logic                 ge_lo;
    logic                 ge_mid;
    logic                 ge_hi;
    logic                 near_lo;
    logic                 near_mid;
    logic                 near_hi;

    assign sx = {{2{sample[SAMPLE_WIDTH-1]}}, sample};

    // Threshold comparisons; ">=" makes ties resolve to the higher level.
    always_comb begin
        ge_lo    = (sx >= THR_LO);
        ge_mid   = (sx >= THR_MID);
        ge_hi    = (sx >= THR_HI);
        near_lo  = (abs_s(sx - THR_LO) < MARGIN_S);
        near_mid = (abs_s(sx - THR_MID) < MARGIN_S);
        near_hi  = (abs_s(sx - THR_HI) < MARGIN_S);
    end

    // Level decision, label and confidence; outer thresholds only exist for 4-PAM.
    always_comb begin
        idx   = 2'd0;
        label = 2'b00;
        near  = near_mid;
        if (IS_PAM4) begin
            if (ge_hi) begin
                idx = 2'd3;
            end else if (ge_mid) begin
                idx = 2'd2;
            end else if (ge_lo) begin
                idx = 2'd1;
            end else begin
                idx = 2'd0;
            end
            label = gray_label(idx);
            near  = near_lo | near_mid | near_hi;
        end else begin
            idx   = {1'b0, ge_mid};
            label = {1'b0, ge_mid};
        end
    end

endmodule

// File: rtl/lattice_decoder.sv
// Three-stage receive decoder: register samples, slice/margin-check, Gray-demap to data word.
module lattice_decoder
    import lattice_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned SCALE        = 32,
    parameter int unsigned MARGIN       = 8,
    parameter int unsigned BITS_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] s0,
    input  logic signed [SAMPLE_WIDTH-1:0] s1,
    input  logic signed [SAMPLE_WIDTH-1:0] s2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BITS_WIDTH-1:0]          data,
    output logic                           low_conf,
    input  logic                           clr_cnt,
    output logic [CNT_WIDTH-1:0]           sym_cnt,
    output logic [CNT_WIDTH-1:0]           lc_cnt
);

    logic advance;
    logic xfer;

    // S1: registered samples
    logic                           v1_q;
    logic signed [SAMPLE_WIDTH-1:0] s0_q;
    logic signed [SAMPLE_WIDTH-1:0] s1_q;
    logic signed [SAMPLE_WIDTH-1:0] s2_q;

    // S2: slice decisions
    logic       v2_q;
    level_idx_t idx0_q;
    level_idx_t idx1_q;
    logic       bit2_q;
    logic       near_q;

    // S3: output stage
    logic                  v3_q;
    logic [BITS_WIDTH-1:0] data_q;
    logic [BITS_WIDTH-1:0] data_d;
    logic                  low_conf_q;

    logic [CNT_WIDTH-1:0] sym_cnt_q;
    logic [CNT_WIDTH-1:0] sym_cnt_d;
    logic [CNT_WIDTH-1:0] lc_cnt_q;
    logic [CNT_WIDTH-1:0] lc_cnt_d;

    level_idx_t  idx0;
    level_idx_t  idx1;
    level_idx_t  idx2;
    gray_label_t lab0;
    gray_label_t lab1;
    gray_label_t lab2;
    logic        near0;
    logic        near1;
    logic        near2;

    // Global stall: every stage moves together whenever the output slot can be freed.
    always_comb begin
        advance  = !v3_q || out_ready;
        in_ready = advance;
        xfer     = v3_q && out_ready;
    end

    pam_slicer #(
        .LEVELS       (4),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SCALE        (SCALE),
        .MARGIN       (MARGIN)
    ) u_slice0 (
        .sample (s0_q),
        .idx    (idx0),
        .label  (lab0),
        .near   (near0)
    );

    pam_slicer #(
        .LEVELS       (4),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SCALE        (SCALE),
        .MARGIN       (MARGIN)
    ) u_slice1 (
        .sample (s1_q),
        .idx    (idx1),
        .label  (lab1),
        .near   (near1)
    );

    pam_slicer #(
        .LEVELS       (2),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SCALE        (SCALE),
        .MARGIN       (MARGIN)
    ) u_slice2 (
        .sample (s2_q),
        .idx    (idx2),
        .label  (lab2),
        .near   (near2)
    );

    // Labels are rebuilt from the registered indices in S3; the slicer copies are spare.
    logic unused_slice;
    assign unused_slice = ^{lab0, lab1, lab2, idx2[1]};

    // S1: capture the sample triple on an input transfer; bubbles carry v1_q=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else if (advance) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s0_q <= s0;
                s1_q <= s1;
                s2_q <= s2;
            end
        end
    end

    // S2: register slice decisions and the combined low-confidence flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q   <= 1'b0;
            idx0_q <= '0;
            idx1_q <= '0;
            bit2_q <= 1'b0;
            near_q <= 1'b0;
        end else if (advance) begin
            v2_q <= v1_q;
            if (v1_q) begin
                idx0_q <= idx0;
                idx1_q <= idx1;
                bit2_q <= idx2[0];
                near_q <= near0 | near1 | near2;
            end
        end
    end

    // S3 next word: Gray-demap each dimension into the packed data word.
    always_comb begin
        data_d = BITS_WIDTH'({gray_label(idx0_q), gray_label(idx1_q), bit2_q});
    end

    // S3: output register; payload only reloads for a real word so it stays quiet on bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3_q       <= 1'b0;
            data_q     <= '0;
            low_conf_q <= 1'b0;
        end else if (advance) begin
            v3_q <= v2_q;
            if (v2_q) begin
                data_q     <= data_d;
                low_conf_q <= near_q;
            end
        end
    end

    // Counter next state: clear wins over increment, both saturate at all-ones.
    always_comb begin
        sym_cnt_d = sym_cnt_q;
        lc_cnt_d  = lc_cnt_q;
        if (clr_cnt) begin
            sym_cnt_d = '0;
            lc_cnt_d  = '0;
        end else if (xfer) begin
            if (sym_cnt_q != '1) begin
                sym_cnt_d = sym_cnt_q + CNT_WIDTH'(1);
            end
            if (low_conf_q && (lc_cnt_q != '1)) begin
                lc_cnt_d = lc_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt_q <= '0;
            lc_cnt_q  <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            lc_cnt_q  <= lc_cnt_d;
        end
    end

    assign out_valid = v3_q;
    assign data      = data_q;
    assign low_conf  = low_conf_q;
    assign sym_cnt   = sym_cnt_q;
    assign lc_cnt    = lc_cnt_q;

endmodule

// File: tb/tb_lattice_decoder.sv
// Directed self-checking bench for lattice_decoder.
module tb_lattice_decoder;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic              clr_cnt;
    logic signed [7:0] s0;
    logic signed [7:0] s1;
    logic signed [7:0] s2;

    logic        in_ready;
    logic        out_valid;
    logic [4:0]  data;
    logic        low_conf;
    logic [15:0] sym_cnt;
    logic [15:0] lc_cnt;

    logic        in_ready_sm;
    logic        out_valid_sm;
    logic [4:0]  data_sm;
    logic        low_conf_sm;
    logic [3:0]  sym_cnt_sm;
    logic [3:0]  lc_cnt_sm;

    int checks   = 0;
    int failures = 0;

    // {low_conf, data} of every output transfer, in order
    logic [5:0] q_out[$];

    always #5 clk = ~clk;

    lattice_decoder #(
        .SAMPLE_WIDTH (8),
        .SCALE        (32),
        .MARGIN       (8),
        .BITS_WIDTH   (5),
        .CNT_WIDTH    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .low_conf  (low_conf),
        .clr_cnt   (clr_cnt),
        .sym_cnt   (sym_cnt),
        .lc_cnt    (lc_cnt)
    );

    // Narrow-counter copy fed the same stream, for saturation checks.
    lattice_decoder #(
        .SAMPLE_WIDTH (8),
        .SCALE        (32),
        .MARGIN       (8),
        .BITS_WIDTH   (5),
        .CNT_WIDTH    (4)
    ) dut_sm (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_sm),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .out_valid (out_valid_sm),
        .out_ready (out_ready),
        .data      (data_sm),
        .low_conf  (low_conf_sm),
        .clr_cnt   (clr_cnt),
        .sym_cnt   (sym_cnt_sm),
        .lc_cnt    (lc_cnt_sm)
    );

    always @(negedge clk) begin
        if (out_valid && out_ready) q_out.push_back({low_conf, data});
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ideal 4-PAM sample for a Gray label.
    function automatic logic signed [7:0] lvl4(input logic [1:0] lab);
        case (lab)
            2'b00:   return -8'sd96;
            2'b01:   return -8'sd32;
            2'b11:   return 8'sd32;
            default: return 8'sd96;
        endcase
    endfunction

    task automatic set_word(input logic [4:0] w);
        s0 = lvl4(w[4:3]);
        s1 = lvl4(w[2:1]);
        s2 = w[0] ? 8'sd32 : -8'sd32;
    endtask

    logic signed [7:0] th_s[6];
    logic [5:0]        th_e[6];
    logic [5:0]        hold;
    logic [4:0]        bp_w;
    logic              acc;
    int                idx;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        s0 = '0; s1 = '0; s2 = '0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_low_conf", 32'(low_conf), 32'd0);
        chk("rst_sym_cnt", 32'(sym_cnt), 32'd0);
        chk("rst_lc_cnt", 32'(lc_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        rst = 1'b1;

        // Decode mapping and latency
        s0 = -8'sd96; s1 = 8'sd32; s2 = 8'sd32; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat1_e1", 32'(out_valid), 32'd0);
        step();
        chk("lat1_e2", 32'(out_valid), 32'd0);
        step();
        chk("lat1_e3", 32'(out_valid), 32'd1);
        chk("map1_data", 32'(data), 32'b00111);
        chk("map1_lc", 32'(low_conf), 32'd0);
        s0 = 8'sd96; s1 = -8'sd32; s2 = -8'sd32; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat2_e1", 32'(out_valid), 32'd0);
        step();
        step();
        chk("lat2_e3", 32'(out_valid), 32'd1);
        chk("map2_data", 32'(data), 32'b10010);
        chk("map2_lc", 32'(low_conf), 32'd0);
        step();
        chk("map_sym_cnt", 32'(sym_cnt), 32'd2);
        q_out.delete();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_sym_cnt", 32'(sym_cnt), 32'd0);

        // Round trip over all 32 ideal points
        for (int w = 0; w < 32; w++) begin
            set_word(5'(w));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("rt_count", 32'(q_out.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rt_word%0d", i), 32'(q_out[i]), 32'(i));
        end
        chk("rt_sym_cnt", 32'(sym_cnt), 32'd32);
        chk("rt_lc_cnt", 32'(lc_cnt), 32'd0);
        chk("rt_sym_sat", 32'(sym_cnt_sm), 32'd15);
        q_out.delete();

        // Thresholds, ties, margin edges and saturation on dim0
        th_s = '{8'sd0, 8'sd64, -8'sd64, 8'sh80, 8'sd8, -8'sd7};
        th_e = '{6'b111000, 6'b110000, 6'b101000, 6'b000000, 6'b011000, 6'b101000};
        for (int i = 0; i < 6; i++) begin
            s0 = th_s[i]; s1 = -8'sd96; s2 = -8'sd32; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("th_count", 32'(q_out.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("th_word%0d", i), 32'(q_out[i]), 32'(th_e[i]));
        end
        chk("th_lc_cnt", 32'(lc_cnt), 32'd4);
        chk("th_sym_cnt", 32'(sym_cnt), 32'd38);
        chk("th_sym_sat", 32'(sym_cnt_sm), 32'd15);
        chk("th_lc_sm", 32'(lc_cnt_sm), 32'd4);
        q_out.delete();

        // Backpressure: 10 words, out_ready low for cycles 5..9
        idx = 0;
        hold = '0;
        for (int cyc = 0; cyc < 60 && q_out.size() < 10; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 10);
            if (idx < 10) begin
                bp_w = 5'((idx * 7 + 3) % 32);
                set_word(bp_w);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 5) begin
                chk("bp_stall_valid", 32'(out_valid), 32'd1);
                hold = {low_conf, data};
            end
            if (!out_ready) chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (cyc > 5 && cyc <= 10) chk("bp_hold", 32'({low_conf, data}), 32'(hold));
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(q_out.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_word%0d", i), 32'(q_out[i]), 32'((i * 7 + 3) % 32));
        end
        q_out.delete();

        // Clear coincident with a transfer
        set_word(5'd5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) step();
        chk("clr_wait_valid", 32'(out_valid), 32'd1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clrx_transfer", 32'(q_out.size()), 32'd1);
        chk("clrx_sym_cnt", 32'(sym_cnt), 32'd0);
        chk("clrx_lc_cnt", 32'(lc_cnt), 32'd0);
        chk("clrx_sym_sm", 32'(sym_cnt_sm), 32'd0);
        chk("clrx_lc_sm", 32'(lc_cnt_sm), 32'd0);
        q_out.delete();

        // 20 words: wide counter counts, narrow one holds at 15
        for (int w = 0; w < 20; w++) begin
            set_word(5'(w));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("sat_sym_cnt", 32'(sym_cnt), 32'd20);
        chk("sat_sym_sm", 32'(sym_cnt_sm), 32'd15);
        q_out.delete();

        // Reset with 3 words in flight
        for (int w = 0; w < 3; w++) begin
            set_word(5'(10 + w));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("mrst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data", 32'(data), 32'd0);
        chk("mrst_lc", 32'(low_conf), 32'd0);
        chk("mrst_sym_cnt", 32'(sym_cnt), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst = 1'b1;
        step();
        chk("mrst_flush1", 32'(out_valid), 32'd0);
        step();
        chk("mrst_flush2", 32'(out_valid), 32'd0);
        set_word(5'd22);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_e1", 32'(out_valid), 32'd0);
        step();
        chk("mrst_e2", 32'(out_valid), 32'd0);
        step();
        chk("mrst_e3", 32'(out_valid), 32'd1);
        chk("mrst_data_new", 32'(data), 32'd22);
        step();
        chk("mrst_count", 32'(q_out.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
